// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event field layout for the PS/2 key event decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int EVT_BRK = 9;
  localparam int EVT_EXT = 8;
  localparam int EVT_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } ps2_state_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Receiver byte handshake plus event stream seen by the decoder.
interface ps2_key_event_decoder_if;
  import ps2_pkg::*;

  logic             ready;
  logic [7:0]       data;
  logic             nextdata_n;
  logic             evt_valid;
  logic [EVT_W-1:0] evt_data;
  logic             evt_ready;

  modport master (output ready, data, evt_ready, input nextdata_n, evt_valid, evt_data);
  modport slave  (input ready, data, evt_ready, output nextdata_n, evt_valid, evt_data);
endinterface

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO updated on the falling edge; head is readable without a pop.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  always_ff @(negedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Decodes E0/F0 prefixed PS/2 scan bytes into {brk, ext, code} events with held-key tracking.
//   state   | meaning
//   IDLE    | no prefix pending
//   E0      | extended prefix seen
//   F0      | break prefix seen
//   E0F0    | extended break prefix seen
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int CNT_W         = 8,
  parameter int FILTER_REPEAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  ps2_key_event_decoder_if.slave    bus,
  output logic                      key_down,
  output logic [8:0]                held_code,
  output logic [CNT_W-1:0]          make_cnt,
  output logic [7:0]                err_cnt,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  ps2_state_t       state;
  ps2_state_t       state_nxt;
  logic             nd_pulse;
  logic             byte_ext;
  logic             byte_brk;
  logic             pfx;
  logic             suppress;
  logic             accept;
  logic             push;
  logic             do_make;
  logic             do_break;
  logic             proto_err;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EVT_W-1:0] evt_word;

  assign byte_ext = (state == ST_E0) || (state == ST_E0F0);
  assign byte_brk = (state == ST_F0) || (state == ST_E0F0);
  assign pfx      = is_prefix(bus.data);
  // A repeat that will be dropped needs no FIFO slot, so it is taken even when full.
  assign suppress = (FILTER_REPEAT != 0) && !byte_brk && key_down &&
                    ({byte_ext, bus.data} == held_code);
  assign accept   = bus.ready && !nd_pulse && (pfx || suppress || !fifo_full);
  assign do_make  = accept && !pfx && !byte_brk && !suppress;
  assign do_break = accept && !pfx && byte_brk;
  assign push     = do_make || do_break;

  always_ff @(negedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    proto_err = 1'b0;
    if (accept) begin
      if (bus.data == PS2_EXT) begin
        state_nxt = ST_E0;
        proto_err = (state != ST_IDLE);
      end else if (bus.data == PS2_BRK) begin
        state_nxt = (state == ST_E0) ? ST_E0F0 : ST_F0;
        proto_err = byte_brk;
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_comb begin
    evt_word          = '0;
    evt_word[EVT_BRK] = byte_brk;
    evt_word[EVT_EXT] = byte_ext;
    evt_word[7:0]     = bus.data;
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      nd_pulse  <= 1'b0;
      key_down  <= 1'b0;
      held_code <= '0;
      make_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      nd_pulse <= accept;
      if (proto_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (do_make) begin
        make_cnt  <= make_cnt + 1'b1;
        held_code <= {byte_ext, bus.data};
        key_down  <= 1'b1;
      end
      if (do_break && ({byte_ext, bus.data} == held_code)) key_down <= 1'b0;
    end
  end

  assign bus.nextdata_n = !nd_pulse;
  assign bus.evt_valid  = !fifo_empty;

  ps2_evt_fifo #(.DEPTH(DEPTH), .WIDTH(EVT_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (evt_word),
    .pop       (bus.evt_ready),
    .head      (bus.evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench: two decoder builds (default and DEPTH=2/CNT_W=2/no filter) with an event scoreboard.
module tb_ps2_key_event_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic       b_ready;
  logic       b_evt_ready;
  logic [7:0] b_data;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] sb[$];
  logic [7:0] codes[5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};

  ps2_key_event_decoder_if ifa();
  ps2_key_event_decoder_if ifb();

  logic       kd_a, kd_b;
  logic [8:0] hc_a, hc_b;
  logic [7:0] mc_a, ec_a, ec_b;
  logic [1:0] mc_b, lv_b;
  logic [3:0] lv_a;

  ps2_key_event_decoder #(.DEPTH(8), .CNT_W(8), .FILTER_REPEAT(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .key_down(kd_a), .held_code(hc_a),
    .make_cnt(mc_a), .err_cnt(ec_a), .fifo_level(lv_a));

  ps2_key_event_decoder #(.DEPTH(2), .CNT_W(2), .FILTER_REPEAT(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .key_down(kd_b), .held_code(hc_b),
    .make_cnt(mc_b), .err_cnt(ec_b), .fifo_level(lv_b));

  assign ifa.ready     = b_ready & ~sel;
  assign ifa.data      = b_data;
  assign ifa.evt_ready = b_evt_ready & ~sel;
  assign ifb.ready     = b_ready & sel;
  assign ifb.data      = b_data;
  assign ifb.evt_ready = b_evt_ready & sel;

  logic       o_nd, o_valid, o_kd;
  logic [9:0] o_data;
  logic [8:0] o_hc;
  logic [7:0] o_mc, o_ec;
  logic [3:0] o_lv;

  always_comb begin
    if (sel) begin
      o_nd = ifb.nextdata_n; o_valid = ifb.evt_valid; o_data = ifb.evt_data;
      o_kd = kd_b; o_hc = hc_b; o_mc = {6'd0, mc_b}; o_ec = ec_b; o_lv = {2'd0, lv_b};
    end else begin
      o_nd = ifa.nextdata_n; o_valid = ifa.evt_valid; o_data = ifa.evt_data;
      o_kd = kd_a; o_hc = hc_a; o_mc = mc_a; o_ec = ec_a; o_lv = lv_a;
    end
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    b_ready = 1'b1;
    b_data  = b;
    t = 0;
    tick();
    while (o_nd !== 1'b0 && t < 20) begin
      tick();
      t++;
    end
    check("nextdata_n_ack", o_nd, 0);
    b_ready = 1'b0;
    tick();
    check("nextdata_n_release", o_nd, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Scoreboard side: a pop happens on the falling edge after each observed valid&ready.
  always begin
    @(posedge clk);
    #2;
    if (reset === 1'b1 && o_valid === 1'b1 && b_evt_ready === 1'b1) begin
      check("sb_event_expected", (sb.size() != 0) ? 1 : 0, 1);
      if (sb.size() != 0) check("evt_data", {22'd0, o_data}, {22'd0, sb.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; reset = 1'b0; b_ready = 1'b0; b_data = 8'h00; b_evt_ready = 1'b1;
    do_reset();
    check("rst_nextdata_n", o_nd, 1);
    check("rst_evt_valid", o_valid, 0);
    check("rst_key_down", o_kd, 0);
    check("rst_held_code", o_hc, 0);
    check("rst_make_cnt", o_mc, 0);
    check("rst_err_cnt", o_ec, 0);
    check("rst_level", o_lv, 0);

    // basic make / break
    sb.push_back(10'h01C); send(8'h1C);
    check("t1_key_down_make", o_kd, 1);
    check("t1_make_cnt", o_mc, 1);
    check("t1_held", o_hc, 9'h01C);
    send(8'hF0); sb.push_back(10'h21C); send(8'h1C);
    check("t1_key_down_break", o_kd, 0);
    check("t1_held_after_break", o_hc, 9'h01C);

    // extended make / break
    send(8'hE0); sb.push_back(10'h175); send(8'h75);
    check("t2_key_down_make", o_kd, 1);
    check("t2_make_cnt", o_mc, 2);
    send(8'hE0); send(8'hF0); sb.push_back(10'h375); send(8'h75);
    check("t2_held", o_hc, 9'h175);
    check("t2_key_down_break", o_kd, 0);

    // typematic repeats filtered
    sb.push_back(10'h01C); send(8'h1C);
    send(8'h1C); send(8'h1C);
    send(8'hF0); sb.push_back(10'h21C); send(8'h1C);
    check("t3_make_cnt", o_mc, 3);
    check("t3_key_down", o_kd, 0);

    // protocol error F0 E0 F0 6B
    send(8'hF0); send(8'hE0); send(8'hF0); sb.push_back(10'h36B); send(8'h6B);
    check("t5_err_cnt", o_ec, 1);
    tick(); tick();
    check("t5_sb_drained", sb.size(), 0);

    // reset after a lone break prefix discards it
    send(8'hF0);
    do_reset();
    check("t6_rst_err_cnt", o_ec, 0);
    check("t6_rst_make_cnt", o_mc, 0);
    check("t6_rst_level", o_lv, 0);
    sb.push_back(10'h01C); send(8'h1C);
    check("t6_make_cnt", o_mc, 1);
    check("t6_key_down", o_kd, 1);
    tick(); tick();

    // second build: no repeat filter
    sel = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(10'h01C); send(8'h1C);
    end
    send(8'hF0); sb.push_back(10'h21C); send(8'h1C);
    check("t3b_make_cnt", o_mc, 3);
    tick(); tick();
    check("t3b_sb_drained", sb.size(), 0);

    // 2-bit make counter wraps
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sb.push_back({2'b00, codes[i]});
      send(codes[i]);
      check("t7_make_cnt_wrap", o_mc, (i + 1) % 4);
    end
    tick(); tick();

    // backpressure with a 2-entry FIFO
    b_evt_ready = 1'b0;
    sb.push_back(10'h015); send(8'h15);
    sb.push_back(10'h01D); send(8'h1D);
    check("t4_level_full", o_lv, 2);
    sb.push_back(10'h024);
    b_ready = 1'b1; b_data = 8'h24;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_held_off", o_nd, 1);
      check("t4_level_hold", o_lv, 2);
      check("t4_head_showahead", o_data, 10'h015);
    end
    b_evt_ready = 1'b1;
    tick();
    b_evt_ready = 1'b0;
    check("t4_level_after_pop", o_lv, 1);
    tick();
    check("t4_accept_24", o_nd, 0);
    check("t4_level_refill", o_lv, 2);
    check("t4_head_1d", o_data, 10'h01D);
    b_ready = 1'b0;
    tick();
    check("t4_release", o_nd, 1);
    b_evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t4_level_empty", o_lv, 0);
    check("final_sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
